// File: rtl/pc_seq_if.sv
// Control/status bundle of the program-counter sequencer. The master drives the control
// inputs and reads the PC and status; the slave is the sequencer itself.
interface pc_seq_if #(
  parameter int INDEX_WIDTH = 9,
  parameter int CNT_WIDTH   = 8
);
  logic                   en;
  logic                   copy_start;
  logic [CNT_WIDTH-1:0]   copy_len;
  logic                   branch_taken;
  logic                   branch_rel;
  logic [INDEX_WIDTH-1:0] branch_target;
  logic                   halt_req;
  logic                   resume;
  logic [INDEX_WIDTH-1:0] pc;
  logic [INDEX_WIDTH-1:0] pc_next;
  logic                   copying;
  logic                   halted;
  logic                   copy_done;
  logic                   wrap;
  logic [1:0]             state_dbg;

  modport master (
    output en, copy_start, copy_len, branch_taken, branch_rel, branch_target, halt_req, resume,
    input  pc, pc_next, copying, halted, copy_done, wrap, state_dbg
  );

  modport slave (
    input  en, copy_start, copy_len, branch_taken, branch_rel, branch_target, halt_req, resume,
    output pc, pc_next, copying, halted, copy_done, wrap, state_dbg
  );
endinterface

// File: rtl/pc_sequencer.sv
// Registered program counter with sequential step, absolute/relative branch,
// counted memory-copy stall and halt/resume. state_dbg exposes the FSM state.
module pc_sequencer #(
  parameter int INDEX_WIDTH  = 9,
  parameter int STEP         = 4,
  parameter int RESET_VECTOR = 0,
  parameter int CNT_WIDTH    = 8
) (
  input logic    clk,
  input logic    reset,
  pc_seq_if.slave bus
);
  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_COPY = 2'd1,
    S_HALT = 2'd2
  } state_t;

  localparam logic [INDEX_WIDTH:0]   STEP_EXT = (INDEX_WIDTH+1)'(STEP);
  localparam logic [INDEX_WIDTH-1:0] RST_PC   = INDEX_WIDTH'(RESET_VECTOR);
  localparam logic [CNT_WIDTH-1:0]   CNT_ONE  = CNT_WIDTH'(1);

  state_t                 state_q;
  logic [INDEX_WIDTH-1:0] pc_q;
  logic [CNT_WIDTH-1:0]   cnt_q;
  logic                   halt_pend_q;
  logic                   copy_done_q;
  logic                   wrap_q;

  logic [INDEX_WIDTH:0]   seq_sum;
  logic [INDEX_WIDTH-1:0] branch_pc;
  logic [INDEX_WIDTH-1:0] pc_d;
  logic                   seq_step;
  logic                   copy_go;
  logic                   copy_last;

  // Extra top bit of seq_sum is the carry that drives the wrap pulse.
  assign seq_sum   = {1'b0, pc_q} + STEP_EXT;
  assign branch_pc = bus.branch_rel ? (pc_q + bus.branch_target) : bus.branch_target;
  assign copy_go   = bus.copy_start && (bus.copy_len != '0);
  assign copy_last = (cnt_q == CNT_ONE);

  always_comb begin
    pc_d     = pc_q;
    seq_step = 1'b0;
    case (state_q)
      S_RUN: begin
        if (bus.halt_req || copy_go) begin
          pc_d = pc_q;
        end else if (bus.branch_taken) begin
          pc_d = branch_pc;
        end else begin
          seq_step = 1'b1;
        end
      end
      S_COPY:  seq_step = copy_last;
      default: seq_step = 1'b0;
    endcase
    if (seq_step) pc_d = seq_sum[INDEX_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_RUN;
      pc_q        <= RST_PC;
      cnt_q       <= '0;
      halt_pend_q <= 1'b0;
      copy_done_q <= 1'b0;
      wrap_q      <= 1'b0;
    end else if (!bus.en) begin
      copy_done_q <= 1'b0;
      wrap_q      <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      wrap_q      <= seq_step & seq_sum[INDEX_WIDTH];
      copy_done_q <= 1'b0;
      case (state_q)
        S_RUN: begin
          if (bus.halt_req) begin
            state_q <= S_HALT;
          end else if (copy_go) begin
            state_q <= S_COPY;
            cnt_q   <= bus.copy_len;
          end
        end
        S_COPY: begin
          if (copy_last) begin
            // A halt requested at any point during the copy takes effect on exit.
            state_q     <= (halt_pend_q || bus.halt_req) ? S_HALT : S_RUN;
            cnt_q       <= '0;
            halt_pend_q <= 1'b0;
            copy_done_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
            if (bus.halt_req) halt_pend_q <= 1'b1;
          end
        end
        S_HALT: begin
          if (bus.resume) state_q <= S_RUN;
        end
        default: state_q <= S_RUN;
      endcase
    end
  end

  assign bus.pc        = pc_q;
  assign bus.pc_next   = bus.en ? pc_d : pc_q;
  assign bus.copying   = (state_q == S_COPY);
  assign bus.halted    = (state_q == S_HALT);
  assign bus.copy_done = copy_done_q & bus.en;
  assign bus.wrap      = wrap_q & bus.en;
  assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios followed by random stimulus, all checked
// against a mode/remaining-cycles reference model.
module tb_pc_sequencer;
  localparam int PC_MOD = 512;
  localparam int STEP   = 4;
  localparam int M_RUN  = 0;
  localparam int M_COPY = 1;
  localparam int M_HALT = 2;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  pc_seq_if #(.INDEX_WIDTH(9), .CNT_WIDTH(8)) bus ();

  pc_sequencer #(
    .INDEX_WIDTH (9),
    .STEP        (4),
    .RESET_VECTOR(0),
    .CNT_WIDTH   (8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state
  int m_pc, m_mode, m_left;
  bit m_pend, m_cd, m_wrap;
  int n_pc, n_mode, n_left;
  bit n_pend, n_cd, n_wrap;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", name, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_pc"},        32'(bus.pc),        32'(m_pc));
    chk({tag, "_copying"},   32'(bus.copying),   32'(m_mode == M_COPY));
    chk({tag, "_halted"},    32'(bus.halted),    32'(m_mode == M_HALT));
    chk({tag, "_copy_done"}, 32'(bus.copy_done), 32'(m_cd));
    chk({tag, "_wrap"},      32'(bus.wrap),      32'(m_wrap));
  endtask

  task automatic set_inputs(input bit e, input bit hr, input bit rs, input bit cs,
                            input int len, input bit bt, input bit br, input int tgt);
    bus.en            = e;
    bus.halt_req      = hr;
    bus.resume        = rs;
    bus.copy_start    = cs;
    bus.copy_len      = len[7:0];
    bus.branch_taken  = bt;
    bus.branch_rel    = br;
    bus.branch_target = tgt[8:0];
  endtask

  // driver: apply one cycle of inputs, predict, check pc_next, clock, check outputs
  task automatic drive(input bit e, input bit hr, input bit rs, input bit cs,
                       input int len, input bit bt, input bit br, input int tgt);
    set_inputs(e, hr, rs, cs, len, bt, br, tgt);
    #1;
    n_pc = m_pc; n_mode = m_mode; n_left = m_left; n_pend = m_pend;
    n_cd = 1'b0; n_wrap = 1'b0;
    if (e) begin
      if (m_mode == M_RUN) begin
        if (hr) n_mode = M_HALT;
        else if (cs && len > 0) begin
          n_mode = M_COPY;
          n_left = len;
        end else if (bt) n_pc = br ? (m_pc + tgt) % PC_MOD : tgt;
        else begin
          n_wrap = (m_pc + STEP >= PC_MOD);
          n_pc   = (m_pc + STEP) % PC_MOD;
        end
      end else if (m_mode == M_COPY) begin
        n_left = m_left - 1;
        if (hr) n_pend = 1'b1;
        if (n_left == 0) begin
          n_wrap = (m_pc + STEP >= PC_MOD);
          n_pc   = (m_pc + STEP) % PC_MOD;
          n_cd   = 1'b1;
          n_mode = (m_pend || hr) ? M_HALT : M_RUN;
          n_pend = 1'b0;
        end
      end else begin
        if (rs) n_mode = M_RUN;
      end
    end
    chk("pc_next", 32'(bus.pc_next), 32'(n_pc));
    @(posedge clk);
    #1;
    m_pc = n_pc; m_mode = n_mode; m_left = n_left; m_pend = n_pend;
    m_cd = n_cd; m_wrap = n_wrap;
    check_outputs("step");
  endtask

  task automatic idle();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 0);
  endtask

  task automatic jump(input int tgt);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0, tgt);
  endtask

  task automatic do_reset();
    set_inputs(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_pc = 0; m_mode = M_RUN; m_left = 0; m_pend = 1'b0; m_cd = 1'b0; m_wrap = 1'b0;
    check_outputs("reset");
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    set_inputs(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 0);
    @(posedge clk);
    #1;

    // T1: reset then sequential stepping
    do_reset();
    chk("t1_reset_pc", 32'(bus.pc), 32'd0);
    repeat (5) idle();
    chk("t1_pc_after_5", 32'(bus.pc), 32'd20);

    // T2: overflow from 508 wraps to 0 with a one-cycle wrap pulse
    jump(508);
    idle();
    chk("t2_pc_wrapped", 32'(bus.pc), 32'd0);
    chk("t2_wrap_pulse", 32'(bus.wrap), 32'd1);
    idle();
    chk("t2_wrap_cleared", 32'(bus.wrap), 32'd0);

    // T3: copy stall of 3 cycles
    jump(16);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 3, 1'b0, 1'b0, 0);
    idle();
    idle();
    chk("t3_pc_held", 32'(bus.pc), 32'd16);
    idle();
    chk("t3_pc_exit", 32'(bus.pc), 32'd20);
    chk("t3_copy_done", 32'(bus.copy_done), 32'd1);
    idle();

    // T4: relative and absolute branches
    jump(40);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b1, 9'h1F8);
    chk("t4_rel_pc", 32'(bus.pc), 32'd32);
    jump(100);
    chk("t4_abs_pc", 32'(bus.pc), 32'd100);

    // T5: halt wins over copy and branch; resume continues from held pc
    jump(8);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 3, 1'b1, 1'b0, 77);
    chk("t5_halted", 32'(bus.halted), 32'd1);
    idle();
    drive(1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0, 0);
    chk("t5_resume_pc", 32'(bus.pc), 32'd8);
    idle();
    chk("t5_step_pc", 32'(bus.pc), 32'd12);

    // T6: halt during copy, then reset during copy
    drive(1'b1, 1'b0, 1'b0, 1'b1, 3, 1'b0, 1'b0, 0);
    idle();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, 0);
    idle();
    chk("t6_halt_after_copy", 32'(bus.halted), 32'd1);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0, 0);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 4, 1'b0, 1'b0, 0);
    idle();
    do_reset();

    // T7: en low freezes a 2-cycle copy
    jump(200);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 2, 1'b0, 1'b0, 0);
    repeat (3) drive(1'b0, 1'b1, 1'b0, 1'b1, 5, 1'b1, 1'b0, 3);
    chk("t7_frozen_copying", 32'(bus.copying), 32'd1);
    idle();
    idle();
    chk("t7_exit_pc", 32'(bus.pc), 32'd204);

    // random stimulus against the model
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        drive($urandom_range(0, 9) != 0,
              $urandom_range(0, 15) == 0,
              $urandom_range(0, 2) == 0,
              $urandom_range(0, 5) == 0,
              int'($urandom_range(0, 4)),
              $urandom_range(0, 3) == 0,
              $urandom_range(0, 1) == 1,
              ($urandom_range(0, 3) == 0) ? int'($urandom_range(500, 511))
                                          : int'($urandom_range(0, 511)));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
